forward_scoreboard: RTL and testbench
=====================================

// Module: forward_scoreboard
// PURPOSE
//  Parametrised EX-stage forwarding and stall controller for the pipeline CPU.
//  Tracks in-flight register writers in a DEPTH-entry shift scoreboard, one entry per stage past EX.
//  Selects the bypass source for each EX operand, and stalls EX when the youngest producer's result is not yet available.
//  Sits beside the ID/EX register; drives the EX operand muxes and the hazard/stall logic.
// PARAMETERS
//  AW        5  register address width
//  NUM_SRC   2  operand ports checked in EX (rs, rt, ...)
//  DEPTH     2  tracked stages past EX (1=EX/MEM ... DEPTH=MEM/WB)
//  CNT_W     16 width of stall performance counter
//  SW = $clog2(DEPTH+1)  derived localparam, select/ready-stage width
// PORTS
//  clk            in   1            pipeline clock
//  reset          in   1            asynchronous, active-high; clears scoreboard and counter
//  freeze         in   1            global hold (e.g. memory wait); scoreboard and counter hold
//  ex_valid       in   1            EX holds a real instruction
//  ex_regwrite    in   1            EX instruction writes a register
//  ex_rd          in   AW           EX destination register
//  ex_ready_stg   in   SW           first stage (1..DEPTH) at which its result is bypassable
//  ex_src         in   NUM_SRC*AW   EX source registers, port i at [i*AW +: AW]
//  ex_src_used    in   NUM_SRC      port i actually read (unused ports never stall)
//  fwd_sel        out  NUM_SRC*SW   per port: 0=register file, k=bypass from stage k
//  stall          out  1            hold IF/ID/EX, bubble into stage 1
//  stall_cnt      out  CNT_W        saturating count of stall cycles
// BEHAVIOUR
//  - Entry k (1..DEPTH): {vld, rd, rdy}. Reset: all vld=0, stall_cnt=0. Outputs out of reset: fwd_sel=0, stall=0.
//  - Shift on every non-freeze cycle: entry k+1 <= entry k; entry DEPTH is discarded.
//  - Entry 1 on shift:
//    - loads {1, ex_rd, ex_ready_stg} when ex_valid & ex_regwrite & ex_rd!=0 & !stall;
//    - otherwise loads a bubble (vld=0).
//  - freeze=1: all entries and stall_cnt hold. fwd_sel and stall are still computed combinationally.
//  - Per port i, match(k) = vld[k] & rd[k]==ex_src[i] & ex_src[i]!=0.
//    - Youngest match (lowest k) wins; older matches are ignored.
//    - No match, or ex_src_used[i]=0: fwd_sel[i]=0.
//    - Winner k with k >= rdy[k]: fwd_sel[i]=k, no stall from port i.
//    - Winner k with k < rdy[k]: port i requests stall; fwd_sel[i]=0 (don't-care, driven 0).
//  - stall = OR of port requests, gated by ex_valid. Purely combinational from state and inputs; zero latency.
//  - Register 0 is never tracked nor forwarded.
//  - Results leaving stage DEPTH are in the register file, which has write-before-read bypass; no entry is needed for them.
//  - ex_ready_stg: 0 or >DEPTH is illegal and treated as 1 and DEPTH respectively.
//  - stall_cnt increments on stall & !freeze cycles; saturates at all-ones and does not wrap.
//  - Reset asserted mid-operation: scoreboard clears immediately; the first cycle after release behaves as an empty pipeline.
// STRUCTURE
//  - fwd_pkg: entry struct/typedef, SW, and the FWD_RF=0 constant.
//  - Sub-module fwd_match: one operand port against the scoreboard, giving sel + stall request.
//    Instantiated NUM_SRC times via generate.
//  - Top: scoreboard shift register, stall OR, counter.
// TESTING
//  1. Writer r3 (rdy=1) in EX, then reader of r3 -> fwd_sel=1, stall=0; one cycle later a reader of r3 -> fwd_sel=2.
//  2. Load writes r5 (rdy=2), next instruction reads r5 -> stall=1 one cycle, then fwd_sel=2; stall_cnt=1.
//  3. Writers r4 at stage 1 and stage 2 both match -> fwd_sel=1 (youngest wins).
//  4. Writer rd=0 or regwrite=0, reader of r0 -> fwd_sel=0, stall=0; port with src_used=0 never stalls.
//  5. freeze=1 for 3 cycles during a load-use hazard -> entries unchanged, stall held, stall_cnt unchanged.
//     Release -> sequence resumes as in scenario 2.
//  6. Reset mid-stall -> stall=0, fwd_sel=0 during reset; CNT_W=2 with 5 stall cycles -> stall_cnt=3 (saturates).

Source files
------------

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and constants for the EX forwarding scoreboard
package fwd_pkg;

    localparam int FWD_RF     = 0;
    localparam int FWD_AW_MAX = 8;
    localparam int FWD_SW_MAX = 4;

    // Fields are sized for the widest supported build; narrower builds zero-extend.
    typedef struct packed {
        logic                  vld;
        logic [FWD_AW_MAX-1:0] rd;
        logic [FWD_SW_MAX-1:0] rdy;
    } fwd_entry_t;

    function automatic int fwd_sw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - one EX operand against the scoreboard: bypass select and stall request
module fwd_match
    import fwd_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 2,
    parameter int SW    = 2
) (
    input  logic [AW-1:0] src_i,
    input  logic          used_i,
    input  fwd_entry_t    sb_i [DEPTH],
    output logic [SW-1:0] sel_o,
    output logic          req_o
);

    logic found;

    // Scan from the youngest stage; the first hit shadows every older writer.
    always_comb begin
        sel_o = SW'(FWD_RF);
        req_o = 1'b0;
        found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && used_i && (src_i != '0) && sb_i[k].vld &&
                (sb_i[k].rd == FWD_AW_MAX'(src_i))) begin
                found = 1'b1;
                if (sb_i[k].rdy <= FWD_SW_MAX'(k + 1)) begin
                    sel_o = SW'(k + 1);
                end else begin
                    req_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - EX-stage forwarding select and load-use stall controller
module forward_scoreboard
    import fwd_pkg::*;
#(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16,
    localparam int SW     = fwd_sw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  freeze,
    input  logic                  ex_valid,
    input  logic                  ex_regwrite,
    input  logic [AW-1:0]         ex_rd,
    input  logic [SW-1:0]         ex_ready_stg,
    input  logic [NUM_SRC*AW-1:0] ex_src,
    input  logic [NUM_SRC-1:0]    ex_src_used,
    output logic [NUM_SRC*SW-1:0] fwd_sel,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cnt
);

    fwd_entry_t       sb_q [DEPTH];
    fwd_entry_t       sb_d [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [SW-1:0]    rdy_clamp;
    logic [NUM_SRC-1:0] req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_port
            fwd_match #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_match (
                .src_i  (ex_src[gi*AW +: AW]),
                .used_i (ex_src_used[gi]),
                .sb_i   (sb_q),
                .sel_o  (fwd_sel[gi*SW +: SW]),
                .req_o  (req[gi])
            );
        end
    endgenerate

    assign stall     = ex_valid & (|req);
    assign stall_cnt = stall_cnt_q;

    // Out-of-range ready stages are folded into the legal 1..DEPTH window.
    always_comb begin
        rdy_clamp = ex_ready_stg;
        if (ex_ready_stg == '0) begin
            rdy_clamp = SW'(1);
        end else if (ex_ready_stg > SW'(DEPTH)) begin
            rdy_clamp = SW'(DEPTH);
        end
    end

    always_comb begin
        sb_d[0] = '0;
        if (ex_valid && ex_regwrite && (ex_rd != '0) && !stall) begin
            sb_d[0].vld = 1'b1;
            sb_d[0].rd  = FWD_AW_MAX'(ex_rd);
            sb_d[0].rdy = FWD_SW_MAX'(rdy_clamp);
        end
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else if (!freeze) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= sb_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - directed self-checking bench for forward_scoreboard
module tb_forward_scoreboard;

    localparam int AW      = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 2;
    localparam int SW      = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  freeze;
    logic                  ex_valid;
    logic                  ex_regwrite;
    logic [AW-1:0]         ex_rd;
    logic [SW-1:0]         ex_ready_stg;
    logic [NUM_SRC*AW-1:0] ex_src;
    logic [NUM_SRC-1:0]    ex_src_used;
    logic [NUM_SRC*SW-1:0] fwd_sel;
    logic                  stall;
    logic [CNT_W-1:0]      stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    forward_scoreboard #(.AW(AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .ex_valid     (ex_valid),
        .ex_regwrite  (ex_regwrite),
        .ex_rd        (ex_rd),
        .ex_ready_stg (ex_ready_stg),
        .ex_src       (ex_src),
        .ex_src_used  (ex_src_used),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic w, input int rd, input int rdy,
                       input int s0, input int s1, input logic [1:0] used);
        ex_valid     = v;
        ex_regwrite  = w;
        ex_rd        = AW'(rd);
        ex_ready_stg = SW'(rdy);
        ex_src       = {AW'(s1), AW'(s0)};
        ex_src_used  = used;
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(0, 0, 0, 1, 0, 0, 2'b00);
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        freeze = 1'b0;
        do_reset();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sel", 32'(fwd_sel), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);

        // 1: r3 forwarded from stage 1, then stage 2
        drv(1, 1, 3, 1, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 1, 3, 0, 2'b01);
        chk("s1_sel_stage1", 32'(fwd_sel[1:0]), 1);
        chk("s1_nostall", 32'(stall), 0);
        tick();
        drv(1, 0, 0, 1, 0, 3, 2'b10);
        chk("s1_sel_stage2", 32'(fwd_sel[3:2]), 2);
        chk("s1_port0_rf", 32'(fwd_sel[1:0]), 0);

        // 2: load-use on r5
        do_reset();
        drv(1, 1, 5, 2, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 1, 5, 0, 2'b01);
        chk("s2_stall", 32'(stall), 1);
        chk("s2_sel_during_stall", 32'(fwd_sel), 0);
        tick();
        chk("s2_unstall", 32'(stall), 0);
        chk("s2_sel_stage2", 32'(fwd_sel[1:0]), 2);
        chk("s2_cnt", 32'(stall_cnt), 1);

        // 3: youngest writer of r4 wins
        do_reset();
        drv(1, 1, 4, 1, 0, 0, 2'b00);
        tick();
        drv(1, 1, 4, 1, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 1, 4, 4, 2'b11);
        chk("s3_youngest_p0", 32'(fwd_sel[1:0]), 1);
        chk("s3_youngest_p1", 32'(fwd_sel[3:2]), 1);

        // 4: r0, non-writers and unused ports
        do_reset();
        drv(1, 1, 0, 1, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 1, 0, 0, 2'b11);
        chk("s4_r0_sel", 32'(fwd_sel), 0);
        chk("s4_r0_stall", 32'(stall), 0);
        drv(1, 0, 7, 1, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 1, 7, 0, 2'b01);
        chk("s4_noregwrite_sel", 32'(fwd_sel), 0);
        drv(1, 1, 6, 2, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 1, 6, 6, 2'b00);
        chk("s4_unused_stall", 32'(stall), 0);
        chk("s4_unused_sel", 32'(fwd_sel), 0);
        drv(0, 0, 0, 1, 6, 0, 2'b01);
        chk("s4_invalid_stall", 32'(stall), 0);
        drv(1, 0, 0, 1, 6, 0, 2'b01);
        chk("s4_used_stall", 32'(stall), 1);

        // 5: freeze during load-use
        do_reset();
        drv(1, 1, 5, 2, 0, 0, 2'b00);
        tick();
        freeze = 1'b1;
        drv(1, 0, 0, 1, 5, 0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            chk("s5_frz_stall", 32'(stall), 1);
            chk("s5_frz_cnt", 32'(stall_cnt), 0);
            tick();
        end
        freeze = 1'b0;
        #1;
        chk("s5_rel_stall", 32'(stall), 1);
        chk("s5_rel_sel", 32'(fwd_sel), 0);
        tick();
        chk("s5_after_stall", 32'(stall), 0);
        chk("s5_after_sel", 32'(fwd_sel[1:0]), 2);
        chk("s5_after_cnt", 32'(stall_cnt), 1);

        // 6: async reset mid-stall, then ready-stage clamping and counter saturation
        drv(1, 1, 5, 2, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 1, 5, 0, 2'b01);
        chk("s6_pre_stall", 32'(stall), 1);
        reset = 1'b1;
        #1;
        chk("s6_rst_stall", 32'(stall), 0);
        chk("s6_rst_sel", 32'(fwd_sel), 0);
        chk("s6_rst_cnt", 32'(stall_cnt), 0);
        reset = 1'b0;
        #1;
        chk("s6_post_stall", 32'(stall), 0);
        tick();

        drv(1, 1, 9, 0, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 1, 9, 0, 2'b01);
        chk("s6_rdy0_stall", 32'(stall), 0);
        chk("s6_rdy0_sel", 32'(fwd_sel[1:0]), 1);
        tick();
        drv(1, 1, 10, 3, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 1, 0, 10, 2'b10);
        chk("s6_rdy3_stall", 32'(stall), 1);
        tick();
        chk("s6_rdy3_sel", 32'(fwd_sel[3:2]), 2);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 5, 2, 0, 0, 2'b00);
            tick();
            drv(1, 0, 0, 1, 5, 0, 2'b01);
            chk("s6_loop_stall", 32'(stall), 1);
            tick();
            if (i == 1) chk("s6_cnt2", 32'(stall_cnt), 2);
        end
        chk("s6_cnt_sat", 32'(stall_cnt), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
